// File: rtl/cycle_stim_pkg.sv
// Shared types and defaults for the cycle stimulus scheduler.
//   pulse_state_t : LOW/HIGH state of a pulse stretcher FSM
//   DEF_*         : default parameter values for a 50 MHz board clock
//   acc_width()   : width of the phase accumulator for a given wrap value
package cycle_stim_pkg;

    typedef enum logic [0:0] {PS_LOW, PS_HIGH} pulse_state_t;

    localparam int unsigned DEF_TICK_DIV    = 50000;
    localparam int unsigned DEF_ACC_WRAP    = 4096;
    localparam int unsigned DEF_PULSE_TICKS = 2;
    localparam int unsigned DEF_CRANK_DIV   = 3;

    function automatic int unsigned acc_width(input int unsigned acc_wrap);
        return $clog2(acc_wrap) + 1;
    endfunction

endpackage

// File: rtl/pulse_stretcher.sv
// Turns single-cycle events into pulses PULSE_TICKS scheduler ticks wide.
// An event arriving while a pulse is high is remembered (depth 1) and replayed
// after a one-cycle low gap so the next rising edge stays visible.
//   clk_i   : system clock
//   rst_ni  : asynchronous active-low reset
//   tick_i  : scheduler tick strobe, times the pulse width
//   event_i : single-cycle request for a pulse
//   pulse_o : stretched pulse, active high
module pulse_stretcher
    import cycle_stim_pkg::*;
#(
    parameter int unsigned PULSE_TICKS = DEF_PULSE_TICKS
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic tick_i,
    input  logic event_i,
    output logic pulse_o
);

    localparam int unsigned CW = $clog2(PULSE_TICKS + 1);
    localparam logic [CW-1:0] WIDTH_LOAD = CW'(PULSE_TICKS);

    pulse_state_t  state_q, state_d;
    logic [CW-1:0] width_q, width_d;
    logic          pending_q, pending_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= PS_LOW;
            width_q   <= '0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            width_q   <= width_d;
            pending_q <= pending_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        width_d   = width_q;
        pending_d = pending_q;
        unique case (state_q)
            PS_LOW: begin
                if (event_i || pending_q) begin
                    state_d   = PS_HIGH;
                    width_d   = WIDTH_LOAD;
                    pending_d = 1'b0;
                end
            end
            PS_HIGH: begin
                // A second request while pending is already set is dropped.
                if (event_i) begin
                    pending_d = 1'b1;
                end
                if (tick_i) begin
                    width_d = width_q - CW'(1);
                    if (width_q == CW'(1)) begin
                        state_d = PS_LOW;
                    end
                end
            end
        endcase
    end

    always_comb begin
        pulse_o = (state_q == PS_HIGH);
    end

endmodule

// File: rtl/cycle_stimulus_scheduler.sv
// Generates Wheel and Crank sensor pulse trains for the cycle computer core.
// A prescaler produces a tick every TICK_DIV clocks; on each tick a phase
// accumulator advances by SpeedSel and every wrap past ACC_WRAP is a wheel
// event. Every CRANK_DIV-th wheel event is also a crank event.
//   Clock      : system clock
//   nReset     : asynchronous active-low reset
//   SpeedSel   : accumulator increment per tick, 0 = stationary
//   Enable     : 1 = schedule events, 0 = hold accumulator
//   Wheel      : wheel sensor pulse, active high
//   Crank      : crank sensor pulse, active high
//   WheelCount : wheel events since reset, wraps modulo 2^16
//   Tick       : one-clock strobe per scheduler tick
module cycle_stimulus_scheduler
    import cycle_stim_pkg::*;
#(
    parameter int unsigned TICK_DIV          = DEF_TICK_DIV,
    parameter int unsigned ACC_WRAP          = DEF_ACC_WRAP,
    parameter int unsigned PULSE_TICKS       = DEF_PULSE_TICKS,
    parameter int unsigned CRANK_DIV         = DEF_CRANK_DIV,
    // Scaled-down builds with a small ACC_WRAP may clear this; they must then
    // keep SpeedSel <= ACC_WRAP so a single subtraction still wraps correctly.
    parameter bit          CHECK_SPEED_RANGE = 1'b1
) (
    input  logic        Clock,
    input  logic        nReset,
    input  logic [7:0]  SpeedSel,
    input  logic        Enable,
    output logic        Wheel,
    output logic        Crank,
    output logic [15:0] WheelCount,
    output logic        Tick
);

    localparam int unsigned PW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned AW  = acc_width(ACC_WRAP);
    // Sum must hold the largest acc plus the largest SpeedSel without overflow.
    localparam int unsigned SW  = ((AW > 8) ? AW : 8) + 1;
    localparam int unsigned CDW = (CRANK_DIV > 1) ? $clog2(CRANK_DIV) : 1;

    localparam logic [PW-1:0]  TICK_LAST  = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0]  WRAP_VAL   = SW'(ACC_WRAP);
    localparam logic [CDW-1:0] CRANK_LAST = CDW'(CRANK_DIV - 1);

    if (CHECK_SPEED_RANGE && (ACC_WRAP <= 255)) begin : g_bad_wrap
        $error("ACC_WRAP must exceed the largest SpeedSel (255)");
    end
    if ((PULSE_TICKS < 1) || (CRANK_DIV < 1) || (TICK_DIV < 1)) begin : g_bad_param
        $error("TICK_DIV, PULSE_TICKS and CRANK_DIV must all be at least 1");
    end

    logic [PW-1:0]  presc_q, presc_d;
    logic [AW-1:0]  acc_q, acc_d;
    logic [CDW-1:0] crank_div_q, crank_div_d;
    logic [15:0]    count_q, count_d;

    logic [SW-1:0]  sum;
    logic           advance;
    logic           wheel_evt;
    logic           crank_evt;

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            presc_q     <= '0;
            acc_q       <= '0;
            crank_div_q <= '0;
            count_q     <= '0;
        end else begin
            presc_q     <= presc_d;
            acc_q       <= acc_d;
            crank_div_q <= crank_div_d;
            count_q     <= count_d;
        end
    end

    always_comb begin
        Tick    = (presc_q == TICK_LAST);
        presc_d = Tick ? '0 : presc_q + PW'(1);
    end

    // SpeedSel is only looked at on a tick, so mid-tick changes take effect
    // at the next tick and never disturb a pulse already in flight.
    always_comb begin
        sum       = SW'(acc_q) + SW'(SpeedSel);
        advance   = Tick && Enable && (SpeedSel != 8'd0);
        wheel_evt = advance && (sum >= WRAP_VAL);
        acc_d     = acc_q;
        if (advance) begin
            acc_d = wheel_evt ? AW'(sum - WRAP_VAL) : AW'(sum);
        end
    end

    always_comb begin
        crank_evt   = wheel_evt && (crank_div_q == CRANK_LAST);
        crank_div_d = crank_div_q;
        if (wheel_evt) begin
            crank_div_d = crank_evt ? '0 : crank_div_q + CDW'(1);
        end
        count_d = count_q + 16'(wheel_evt);
    end

    always_comb begin
        WheelCount = count_q;
    end

    pulse_stretcher #(
        .PULSE_TICKS(PULSE_TICKS)
    ) u_wheel_pulse (
        .clk_i  (Clock),
        .rst_ni (nReset),
        .tick_i (Tick),
        .event_i(wheel_evt),
        .pulse_o(Wheel)
    );

    pulse_stretcher #(
        .PULSE_TICKS(PULSE_TICKS)
    ) u_crank_pulse (
        .clk_i  (Clock),
        .rst_ni (nReset),
        .tick_i (Tick),
        .event_i(crank_evt),
        .pulse_o(Crank)
    );

endmodule
